polyshift_pipe: RTL
===================

POLYSHIFT_PIPE -- requirements
Module: polyshift_pipe

Interface
REQ-001 SHALL provide parameter word_width, default 8, meaning data width; legal values are powers of two from 4 to 64.
REQ-002 SHALL provide localparam shift_width = $clog2(word_width), meaning the shift-amount width and the pipeline stage count.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port D_IN, input, word_width, the operand.
REQ-006 SHALL have port C_IN, input, word_width-1, the double-precision fill word for RCR/RCL.
REQ-007 SHALL have port shift_size, input, shift_width, the shift amount (0..word_width-1).
REQ-008 SHALL have port shift_type, input, SHIFT_TYPE, encoded 0 logical, 1 arithmetic, 2 through-carry, 3 rotate.
REQ-009 SHALL have port shift_left, input, 1: 1 selects left, 0 selects right.
REQ-010 SHALL have ports IN_VALID (input, 1) and IN_READY (output, 1), the upstream handshake.
REQ-011 SHALL have ports OUT_VALID (output, 1) and OUT_READY (input, 1), the downstream handshake.
REQ-012 SHALL have port D_OUT, output, word_width, the result.

Function
REQ-013 SHALL accept a transfer on a rising edge where IN_VALID and IN_READY are both 1.
REQ-014 SHALL decompose each shift into shift_width stages; stage i applies a shift of 2^i when shift_size[i]=1, with one register after every stage.
REQ-015 SHALL present the result of a transfer accepted at edge E with OUT_VALID=1 after edge E+shift_width-1, provided there is no stall.
REQ-016 SHALL implement a global stall: advance = !OUT_VALID | OUT_READY; IN_READY = advance; while advance=0 every stage holds its data and valid bit.
REQ-017 SHALL sustain one result per cycle when OUT_READY=1 continuously, and SHALL propagate bubbles (valid=0) without holding up later stages beyond the global stall rule.
REQ-018 SHALL produce, for right shifts: logical = D_IN>>n; arithmetic = $signed(D_IN)>>>n; through-carry = low word of {C_IN,D_IN}>>n; rotate = low word of {D_IN,D_IN}>>n.
REQ-019 SHALL produce, for left shifts: logical and arithmetic = D_IN<<n; through-carry = high word of {D_IN,C_IN}<<n; rotate = high word of {D_IN,D_IN}<<n.
REQ-020 SHALL pass D_IN unchanged when n=0, for every type and direction.
REQ-021 SHALL keep D_OUT stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 SHALL drive D_OUT to the last transferred value (no X) while OUT_VALID=0.

Reset
REQ-023 SHALL, when RST_N=0, immediately clear all stage valid bits, OUT_VALID, D_OUT and all flags to 0, independent of CLK.
REQ-024 SHALL discard in-flight operations on reset mid-operation; the first accepted transfer after RST_N rises SHALL behave as after power-up.
REQ-025 SHALL hold IN_READY=1 in reset and after reset while the pipeline is empty.

Configuration
REQ-026 SHALL, with POLYSHIFT_FLAGS_EN defined, add outputs CARRY_OUT (1) and ZERO_OUT (1), pipelined alongside D_OUT and reset to 0.
REQ-027 SHALL set CARRY_OUT to the last bit shifted out: right, D_IN[n-1]; left, D_IN[word_width-n]. For rotate types it is the bit wrapped into the result MSB (right) or LSB (left); it is 0 when n=0.
REQ-028 SHALL set ZERO_OUT=1 exactly when the result is all zero.
REQ-029 SHALL, without POLYSHIFT_FLAGS_EN, omit both ports and their registers, with all other behaviour identical.

Verification (word_width=8, D_IN=8'b10010110, C_IN=7'b0000101, n=3)
REQ-030 SHALL cover the right shifts: SHR gives 00010010, SAR gives 11110010, RCR gives 10110010, ROR gives 11010010, each appearing after edge E+2; CARRY_OUT=1 with flags enabled.
REQ-031 SHALL cover the left shifts: SHL gives 10110000, RCL gives 10110000, ROL gives 10110100; CARRY_OUT=0 for SHL.
REQ-032 SHALL cover back-to-back operation: 8 transfers on consecutive cycles with OUT_READY=1 give 8 consecutive OUT_VALID cycles with results in order.
REQ-033 SHALL cover backpressure: OUT_READY=0 for 5 cycles with the pipeline full gives IN_READY=0 and D_OUT frozen; on release, no result is lost or duplicated.
REQ-034 SHALL cover reset mid-operation: RST_N pulsed low with 2 operations in flight gives OUT_VALID=0 immediately and no stale result after reset.
REQ-035 SHALL cover an exhaustive sweep: all types × both directions × n=0..7 match the reference model; n=0 returns 10010110.

Source files
------------

// File: rtl/polyshift_pipe.sv
// Pipelined barrel shifter: one register per binary shift stage, global stall on the output handshake.
// Optional CARRY_OUT/ZERO_OUT flags are built when POLYSHIFT_FLAGS_EN is defined.
module polyshift_pipe #(
    parameter int word_width = 8,
    localparam int shift_width = $clog2(word_width)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [word_width-1:0]  D_IN,
    input  logic [word_width-2:0]  C_IN,
    input  logic [shift_width-1:0] shift_size,
    input  logic [1:0]             shift_type,
    input  logic                   shift_left,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [word_width-1:0]  D_OUT
`ifdef POLYSHIFT_FLAGS_EN
    ,
    output logic                   CARRY_OUT,
    output logic                   ZERO_OUT
`endif
);

    localparam int vec_width = 2 * word_width;

    localparam logic [1:0] type_logical = 2'd0;
    localparam logic [1:0] type_arith   = 2'd1;
    localparam logic [1:0] type_carry   = 2'd2;
    localparam logic [1:0] type_rotate  = 2'd3;

    // Handshake: a word moves on a rising edge where valid and ready are both 1.
    // The whole pipe advances together whenever the output slot is empty or
    // being drained; otherwise every stage holds, so IN_READY mirrors advance.
    logic advance;

    logic [shift_width-1:0] valid_q;
    logic [vec_width-1:0]   vec_q  [shift_width-1];
    logic [shift_width-1:0] amt_q  [shift_width-1];
    logic [shift_width-2:0] left_q;
    logic [word_width-1:0]  d_out_q;

    logic [vec_width-1:0]   st_in   [shift_width];
    logic [vec_width-1:0]   st_out  [shift_width];
    logic [shift_width-1:0] amt_in  [shift_width];
    logic [shift_width-1:0] left_in;
    logic [shift_width-1:0] vin;

    logic [word_width-1:0]  fill_r;
    logic [word_width-1:0]  fill_l;
    logic [vec_width-1:0]   entry_vec;
    logic [word_width-1:0]  result;

    assign advance   = !OUT_VALID || OUT_READY;
    assign IN_READY  = advance;
    assign OUT_VALID = valid_q[shift_width-1];
    assign D_OUT     = d_out_q;

    // The operand travels inside a double-width vector whose other half holds
    // the bits that shift in; the result is read from the half the operand
    // started in.
    always_comb begin
        fill_r = '0;
        fill_l = '0;
        case (shift_type)
            type_logical: ;
            type_arith:   fill_r = {word_width{D_IN[word_width-1]}};
            type_carry: begin
                fill_r = {1'b0, C_IN};
                fill_l = {C_IN, 1'b0};
            end
            type_rotate: begin
                fill_r = D_IN;
                fill_l = D_IN;
            end
            default: ;
        endcase
        entry_vec = shift_left ? {D_IN, fill_l} : {fill_r, D_IN};
    end

    always_comb begin
        st_in[0]   = entry_vec;
        amt_in[0]  = shift_size;
        left_in[0] = shift_left;
        vin[0]     = IN_VALID;
        for (int i = 0; i < shift_width - 1; i++) begin
            st_in[i+1]   = vec_q[i];
            amt_in[i+1]  = amt_q[i];
            left_in[i+1] = left_q[i];
            vin[i+1]     = valid_q[i];
        end
        for (int i = 0; i < shift_width; i++) begin
            st_out[i] = st_in[i];
            if (amt_in[i][i]) begin
                st_out[i] = left_in[i] ? (st_in[i] << (1 << i)) : (st_in[i] >> (1 << i));
            end
        end
        result = left_in[shift_width-1] ? st_out[shift_width-1][vec_width-1:word_width]
                                        : st_out[shift_width-1][word_width-1:0];
    end

`ifdef POLYSHIFT_FLAGS_EN
    // The last bit shifted out is known from the operand alone, so it is
    // computed on entry and carried down the pipe with its word.
    logic [shift_width-1:0] idx_r;
    logic [shift_width-1:0] idx_l;
    logic                   entry_carry;
    logic [shift_width-2:0] carry_q;
    logic [shift_width-1:0] carry_in;
    logic                   carry_out_q;
    logic                   zero_out_q;

    always_comb begin
        idx_r = shift_size - shift_width'(1);
        idx_l = shift_width'(0) - shift_size;
        if (shift_size == '0) begin
            entry_carry = 1'b0;
        end else begin
            entry_carry = shift_left ? D_IN[idx_l] : D_IN[idx_r];
        end
        carry_in[0] = entry_carry;
        for (int i = 0; i < shift_width - 1; i++) begin
            carry_in[i+1] = carry_q[i];
        end
    end

    assign CARRY_OUT = carry_out_q;
    assign ZERO_OUT  = zero_out_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            left_q  <= '0;
            d_out_q <= '0;
            for (int i = 0; i < shift_width - 1; i++) begin
                vec_q[i] <= '0;
                amt_q[i] <= '0;
            end
`ifdef POLYSHIFT_FLAGS_EN
            carry_q     <= '0;
            carry_out_q <= 1'b0;
            zero_out_q  <= 1'b0;
`endif
        end else if (advance) begin
            valid_q <= vin;
            // Payload only loads with a valid word, so bubbles leave D_OUT at the last result.
            for (int i = 0; i < shift_width - 1; i++) begin
                if (vin[i]) begin
                    vec_q[i]  <= st_out[i];
                    amt_q[i]  <= amt_in[i];
                    left_q[i] <= left_in[i];
`ifdef POLYSHIFT_FLAGS_EN
                    carry_q[i] <= carry_in[i];
`endif
                end
            end
            if (vin[shift_width-1]) begin
                d_out_q <= result;
`ifdef POLYSHIFT_FLAGS_EN
                carry_out_q <= carry_in[shift_width-1];
                zero_out_q  <= (result == '0);
`endif
            end
        end
    end

endmodule
